// File: rtl/mem_responder.sv
// Single-port word memory answering a valid/ready request bus with a fixed 1+WAIT cycle response.
// No backpressure: requests arriving while a response is outstanding are dropped, not queued.
module mem_responder #(
  parameter int          DEPTH = 1024,
  parameter logic [31:0] BASE  = 32'h0000_0000,
  parameter int          WAIT  = 0
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] SPAN     = 32'(DEPTH) << 2;
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] hold_idx;
  logic          hold_rd;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic [31:0]   req_off;
  logic          req_hit;
  logic [AW-1:0] req_idx;
  logic          req_wr;
  logic          req_rd;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_word;

  // Unsigned offset wraps for addresses below BASE, so one compare covers both range ends.
  assign accept  = rst && mem_valid && (state == IDLE || mem_ready);
  assign req_off = mem_addr - BASE;
  assign req_hit = req_off < SPAN;
  assign req_idx = req_off[AW+1:2];
  assign req_wr  = !mem_instr && (mem_wstrb != 4'd0);
  assign req_rd  = req_hit && !req_wr;

  // Only one read is ever pending, and no write can land between its accept and its response.
  assign rd_idx  = accept ? req_idx : hold_idx;
  assign rd_word = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (accept && req_wr && req_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wstrb[i]) mem[req_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      hold_idx  <= '0;
      hold_rd   <= 1'b0;
      mem_ready <= 1'b0;
      mem_rdata <= 32'd0;
    end else if (accept) begin
      state    <= BUSY;
      cnt      <= WAIT_CNT;
      hold_idx <= req_idx;
      hold_rd  <= req_rd;
      if (WAIT_CNT == 4'd0) begin
        mem_ready <= 1'b1;
        mem_rdata <= req_rd ? rd_word : 32'd0;
      end else begin
        mem_ready <= 1'b0;
        mem_rdata <= 32'd0;
      end
    end else if (state == BUSY) begin
      if (mem_ready) begin
        state     <= IDLE;
        mem_ready <= 1'b0;
        mem_rdata <= 32'd0;
      end else begin
        cnt       <= cnt - 4'd1;
        mem_ready <= (cnt == 4'd1);
        mem_rdata <= (cnt == 4'd1 && hold_rd) ? rd_word : 32'd0;
      end
    end
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of 32-bit words in the array (power of two, 16..65536).
REQ-002 SHALL have parameter BASE, default 32'h0000_0000, byte address of word 0 (DEPTH*4-aligned).
REQ-003 SHALL have parameter WAIT, default 0, extra response wait cycles (0..15).
REQ-004 SHALL provide: rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide: clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL provide: mem_valid  input  1  request present.
REQ-007 SHALL provide: mem_instr  input  1  request is instruction fetch.
REQ-008 SHALL provide: mem_addr  input  32  byte address.
REQ-009 SHALL provide: mem_wdata  input  32  write data.
REQ-010 SHALL provide: mem_wstrb  input  4  byte write enables; 0 = read.
REQ-011 SHALL provide: mem_ready  output  1  one-cycle response strobe.
REQ-012 SHALL provide: mem_rdata  output  32  response data, valid when mem_ready=1.

Function
REQ-013 SHALL implement states IDLE and BUSY with a wait counter of 4 bits.
REQ-014 SHALL accept a request in a cycle with mem_valid=1 when state=IDLE or when mem_ready=1 (completing cycle); requests in other cycles are ignored, not queued.
REQ-015 SHALL, on accept, register address, type and data, load counter with WAIT, enter BUSY.
REQ-016 SHALL, in BUSY, decrement counter each cycle; assert mem_ready for exactly one cycle A+1+WAIT, A = accept cycle.
REQ-017 SHALL return to IDLE after the mem_ready cycle unless a new request is accepted in that cycle, in which case it remains BUSY (throughput 1 per cycle at WAIT=0).
REQ-018 SHALL decode word index = (mem_addr - BASE) >> 2; mem_addr[1:0] ignored.
REQ-019 SHALL treat mem_addr < BASE or >= BASE+4*DEPTH as out of range: reads return 0, writes dropped, mem_ready timing unchanged.
REQ-020 SHALL commit writes in the accept cycle, per byte lane i where mem_wstrb[i]=1; other lanes unchanged.
REQ-021 SHALL ignore mem_wstrb when mem_instr=1 (fetch is always a read).
REQ-022 SHALL drive mem_rdata with the addressed word as read after any same-cycle write commit order: a read accepted in cycle A+1 observes a write accepted in cycle A.
REQ-023 SHALL drive mem_rdata=0 for write responses and whenever mem_ready=0.
REQ-024 SHALL keep mem_rdata stable-free: value only defined while mem_ready=1 besides REQ-023 zeroing.
REQ-025 SHALL tolerate mem_addr changing every cycle with mem_valid held high (fetch behaviour); only the accepted address matters.

Reset
REQ-026 SHALL, on rst=0, asynchronously force state=IDLE, counter=0, mem_ready=0, mem_rdata=0.
REQ-027 SHALL abandon an in-flight request on reset; no mem_ready for it after rst returns high.
REQ-028 SHALL not clear array contents on reset; contents are retained.
REQ-029 SHALL accept a request in the first rising edge with rst=1 and mem_valid=1.

Verification
REQ-030 SHALL verify: WAIT=0, write 32'hDEADBEEF strb 4'hF to BASE+8 at cycle 0, read BASE+8 at cycle 1 -> mem_ready cycles 1,2; rdata 0 then 32'hDEADBEEF.
REQ-031 SHALL verify: word 32'h11223344, write strb 4'b0101 data 32'hAABBCCDD -> subsequent read 32'h11BB33DD.
REQ-032 SHALL verify: WAIT=3, mem_valid held 1, addr stepping +4 each cycle -> mem_ready every 4th cycle, rdata from addresses sampled at accept cycles only.
REQ-033 SHALL verify: read BASE+4*DEPTH and write there -> mem_ready on time, rdata 0, array unchanged.
REQ-034 SHALL verify: mem_instr=1 with strb 4'hF at word 5 -> word 5 unchanged, rdata = old word 5.
REQ-035 SHALL verify: WAIT=5, rst low at counter=2 -> mem_ready=0 immediately, no late response; earlier-written data still readable after reset.
